// File: rtl/m_window_generator.sv
// m_window_generator: streaming 3x3 neighbourhood generator with edge replication.
module m_window_generator #(
  parameter int pImgWidth  = 512,
  parameter int pImgHeight = 512
) (
  input  logic       iClk,
  input  logic       iRst,
  input  logic       iEn,
  input  logic       iDataValid,
  input  logic [7:0] iv8Pixel,
  output logic       oReady,
  output logic [7:0] ov8Pixel_a,
  output logic [7:0] ov8Pixel_b,
  output logic [7:0] ov8Pixel_c,
  output logic [7:0] ov8Pixel_d,
  output logic [7:0] ov8Pixel_fij,
  output logic [7:0] ov8Pixel_e,
  output logic [7:0] ov8Pixel_f,
  output logic [7:0] ov8Pixel_g,
  output logic [7:0] ov8Pixel_h,
  output logic       oDataValid,
  output logic       oSof,
  output logic       oEof
);
  localparam int pCW = $clog2(pImgWidth);
  localparam int pRW = $clog2(pImgHeight);
  typedef enum logic [1:0] {FILL, RUN, FLUSH} tState;
  tState state, nextState;
  logic [pCW-1:0] inCol, outCol, rdCol;
  logic [pRW-1:0] inRow, outRow;
  logic [7:0] lineBuf0 [pImgWidth];
  logic [7:0] lineBuf1 [pImgWidth];
  // column vectors are {top, mid, bottom}; col0 is the newest, col1 the one before
  logic [2:0][7:0] col0, col1, newCol, lft, rgt;
  logic accept, flushStep, emit, inColEnd, outColEnd, lastIn, lastOut, rowTop;
  assign oReady = iEn && state != FLUSH;
  always_comb begin
    accept    = oReady && iDataValid;
    flushStep = iEn && state == FLUSH;
    emit      = flushStep || (accept && state == RUN);
    inColEnd  = inCol == pCW'(pImgWidth - 1);
    outColEnd = outCol == pCW'(pImgWidth - 1);
    lastIn    = inColEnd && inRow == pRW'(pImgHeight - 1);
    lastOut   = outColEnd && outRow == pRW'(pImgHeight - 1);
    rowTop    = outRow == '0;
    // during flush the bottom row replicates the last line held in lineBuf0
    rdCol     = state == FLUSH ? (outColEnd ? '0 : outCol + 1'b1) : inCol;
    newCol    = {lineBuf1[rdCol], lineBuf0[rdCol], state == FLUSH ? lineBuf0[rdCol] : iv8Pixel};
    lft       = outCol == '0 ? col0 : col1;
    rgt       = outColEnd ? col0 : newCol;
    nextState = (state == FILL && accept && inRow == pRW'(1) && inCol == '0) ? RUN :
                (state == RUN && accept && lastIn) ? FLUSH :
                (flushStep && lastOut) ? FILL : state;
  end
  always_ff @(posedge iClk)
    if (iRst) state <= FILL;
    else state <= nextState;
  always_ff @(posedge iClk) begin
    if (accept) begin
      lineBuf1[inCol] <= lineBuf0[inCol];
      lineBuf0[inCol] <= iv8Pixel;
    end
    if (accept || flushStep) begin
      col1 <= col0;
      col0 <= newCol;
    end
  end
  always_ff @(posedge iClk) begin
    if (iRst) begin
      inCol        <= '0;
      inRow        <= '0;
      outCol       <= '0;
      outRow       <= '0;
      oDataValid   <= 1'b0;
      oSof         <= 1'b0;
      oEof         <= 1'b0;
      ov8Pixel_a   <= '0;
      ov8Pixel_b   <= '0;
      ov8Pixel_c   <= '0;
      ov8Pixel_d   <= '0;
      ov8Pixel_fij <= '0;
      ov8Pixel_e   <= '0;
      ov8Pixel_f   <= '0;
      ov8Pixel_g   <= '0;
      ov8Pixel_h   <= '0;
    end else begin
      oDataValid <= emit;
      oSof       <= emit && rowTop && outCol == '0;
      oEof       <= emit && lastOut;
      if (accept) begin
        inCol <= inColEnd ? '0 : inCol + 1'b1;
        inRow <= !inColEnd ? inRow : lastIn ? '0 : inRow + 1'b1;
      end
      if (emit) begin
        ov8Pixel_a   <= rowTop ? lft[1] : lft[2];
        ov8Pixel_b   <= rowTop ? col0[1] : col0[2];
        ov8Pixel_c   <= rowTop ? rgt[1] : rgt[2];
        ov8Pixel_d   <= lft[1];
        ov8Pixel_fij <= col0[1];
        ov8Pixel_e   <= rgt[1];
        ov8Pixel_f   <= lft[0];
        ov8Pixel_g   <= col0[0];
        ov8Pixel_h   <= rgt[0];
        outCol       <= outColEnd ? '0 : outCol + 1'b1;
        outRow       <= !outColEnd ? outRow : lastOut ? '0 : outRow + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_m_window_generator.sv
// tb_m_window_generator: directed and random frames against a clamp-arithmetic reference model.
module tb_m_window_generator;
  localparam int W = 4;
  localparam int H = 3;
  logic clk, iRst, iEn, iDataValid, oReady, oDataValid, oSof, oEof;
  logic [7:0] iv8Pixel, pa, pb, pc, pd, pfij, pe, pf, pg, ph;
  logic [71:0] dutWin, expWin;
  logic [7:0] img [W*H];
  logic expV, expSof, expEof;
  int k, e, winCount, nCmp, nBad;

  m_window_generator #(.pImgWidth(W), .pImgHeight(H)) dut (
    .iClk(clk), .iRst(iRst), .iEn(iEn), .iDataValid(iDataValid), .iv8Pixel(iv8Pixel),
    .oReady(oReady), .ov8Pixel_a(pa), .ov8Pixel_b(pb), .ov8Pixel_c(pc), .ov8Pixel_d(pd),
    .ov8Pixel_fij(pfij), .ov8Pixel_e(pe), .ov8Pixel_f(pf), .ov8Pixel_g(pg), .ov8Pixel_h(ph),
    .oDataValid(oDataValid), .oSof(oSof), .oEof(oEof));

  assign dutWin = {pa, pb, pc, pd, pfij, pe, pf, pg, ph};
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    nCmp++;
    if (got !== exp) begin
      nBad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [71:0] pk(input int a, b, c, d, f0, e0, f, g, h);
    return {8'(a), 8'(b), 8'(c), 8'(d), 8'(f0), 8'(e0), 8'(f), 8'(g), 8'(h)};
  endfunction

  function automatic logic [71:0] refWin(input int m);
    logic [71:0] w = '0;
    int r = m / W, c = m % W, rr, cc;
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++) begin
        rr = r + dr < 0 ? 0 : r + dr > H - 1 ? H - 1 : r + dr;
        cc = c + dc < 0 ? 0 : c + dc > W - 1 ? W - 1 : c + dc;
        w = {w[63:0], img[rr*W+cc]};
      end
    return w;
  endfunction

  task automatic checkOut();
    check("valid", oDataValid, expV);
    check("sof", oSof, expSof);
    check("eof", oEof, expEof);
    check("window", dutWin, expWin);
    if (oDataValid) winCount++;
  endtask

  task automatic step(input logic en, input logic dv, input logic [7:0] px);
    logic acc, emit;
    @(negedge clk);
    iEn = en;
    iDataValid = dv;
    iv8Pixel = px;
    #1;
    check("ready", oReady, en && k < W*H);
    acc = en && dv && k < W*H;
    if (acc) begin
      img[k] = px;
      k++;
      emit = k - 1 >= W + 1;
    end else emit = en && k == W*H;
    expV = emit;
    expSof = 1'b0;
    expEof = 1'b0;
    if (emit) begin
      expWin = refWin(e);
      expSof = e == 0;
      expEof = e == W*H - 1;
      e++;
      if (e == W*H) begin
        e = 0;
        k = 0;
      end
    end
    @(posedge clk);
    #1;
    checkOut();
  endtask

  task automatic doReset();
    @(negedge clk);
    iRst = 1'b1;
    iEn = 1'b1;
    iDataValid = 1'b1;
    @(posedge clk);
    #1;
    k = 0;
    e = 0;
    expWin = '0;
    expV = 1'b0;
    expSof = 1'b0;
    expEof = 1'b0;
    checkOut();
    iRst = 1'b0;
  endtask

  task automatic directedFrame();
    winCount = 0;
    for (int i = 0; i < 5; i++) step(1, 1, 8'(i));
    step(1, 1, 8'd5);
    check("firstWin", dutWin, pk(0, 0, 1, 0, 0, 1, 4, 4, 5));
    check("firstSof", oSof, 1);
    step(1, 1, 8'd6);
    step(1, 1, 8'd7);
    step(1, 1, 8'd8);
    check("rightEdge3", dutWin, pk(2, 3, 3, 2, 3, 3, 6, 7, 7));
    step(1, 1, 8'd9);
    check("leftEdge4", dutWin, pk(0, 0, 1, 4, 4, 5, 8, 8, 9));
    step(1, 1, 8'd10);
    check("interior5", dutWin, pk(0, 1, 2, 4, 5, 6, 8, 9, 10));
    step(1, 1, 8'd11);
    step(1, 1, 8'd12);
    step(1, 1, 8'd12);
    repeat (3) step(0, 1, 8'd12);
    repeat (3) step(1, 1, 8'd12);
    check("lastWin", dutWin, pk(6, 7, 7, 10, 11, 11, 10, 11, 11));
    check("lastEof", oEof, 1);
    check("winCount", 72'(winCount), 72'd12);
  endtask

  initial begin
    iRst = 1'b0;
    iEn = 1'b0;
    iDataValid = 1'b0;
    iv8Pixel = '0;
    nCmp = 0;
    nBad = 0;
    doReset();
    directedFrame();
    step(1, 1, 8'd0);
    for (int i = 1; i < 8; i++) step(1, 1, 8'(i));
    doReset();
    directedFrame();
    for (int i = 0; i < 3000; i++)
      if ($urandom_range(299) == 0) doReset();
      else step($urandom_range(9) < 8, $urandom_range(9) < 7, 8'($urandom));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end
endmodule
